// File: rtl/serial_endpoint_if.sv
// Signal bundle between the serial endpoint, the processor's serial port and the host link.
// SERIAL_ENDPOINT_LOOPBACK_EN adds the loopback_in control.
interface serial_endpoint_if;
  logic       cpu_wren_in;
  logic [7:0] cpu_data_in;
  logic       cpu_rden_in;
  logic [7:0] cpu_data_out;
  logic       cpu_valid_out;
  logic       cpu_ready_out;
  logic [7:0] host_tx_data_out;
  logic       host_tx_valid_out;
  logic       host_tx_ready_in;
  logic [7:0] host_rx_data_in;
  logic       host_rx_valid_in;
  logic       host_rx_ready_out;
  logic       clear_err_in;
  logic       overflow_out;
  logic       underflow_out;
`ifdef SERIAL_ENDPOINT_LOOPBACK_EN
  logic       loopback_in;
`endif

  modport slave (
    input  cpu_wren_in, cpu_data_in, cpu_rden_in,
    output cpu_data_out, cpu_valid_out, cpu_ready_out,
    output host_tx_data_out, host_tx_valid_out,
    input  host_tx_ready_in,
    input  host_rx_data_in, host_rx_valid_in,
    output host_rx_ready_out,
    input  clear_err_in,
`ifdef SERIAL_ENDPOINT_LOOPBACK_EN
    input  loopback_in,
`endif
    output overflow_out, underflow_out
  );

  modport master (
    output cpu_wren_in, cpu_data_in, cpu_rden_in,
    input  cpu_data_out, cpu_valid_out, cpu_ready_out,
    input  host_tx_data_out, host_tx_valid_out,
    output host_tx_ready_in,
    output host_rx_data_in, host_rx_valid_in,
    input  host_rx_ready_out,
    output clear_err_in,
`ifdef SERIAL_ENDPOINT_LOOPBACK_EN
    output loopback_in,
`endif
    input  overflow_out, underflow_out
  );
endinterface

// File: rtl/serial_endpoint.sv
// Device-side serial endpoint: CPU->host TX FIFO and host->CPU RX FIFO, show-ahead.
// Define SERIAL_ENDPOINT_LOOPBACK_EN to add a TX->RX internal loopback path.
module serial_endpoint #(
  parameter int DEPTH_LOG2 = 3
) (
  input logic         clock,
  input logic         reset,
  serial_endpoint_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2:0] ptr_t;

  ptr_t       tx_wr, tx_rd, rx_wr, rx_rd;
  logic [7:0] tx_mem [DEPTH];
  logic [7:0] rx_mem [DEPTH];
  logic       overflow, underflow;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic [7:0] tx_head, rx_head;
  logic lb_mode, lb_move;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0] rx_push_data;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign tx_empty = (tx_wr == tx_rd);
  assign rx_empty = (rx_wr == rx_rd);
  assign tx_full  = (tx_wr[DEPTH_LOG2] != tx_rd[DEPTH_LOG2]) &&
                    (tx_wr[DEPTH_LOG2-1:0] == tx_rd[DEPTH_LOG2-1:0]);
  assign rx_full  = (rx_wr[DEPTH_LOG2] != rx_rd[DEPTH_LOG2]) &&
                    (rx_wr[DEPTH_LOG2-1:0] == rx_rd[DEPTH_LOG2-1:0]);

  assign tx_head = tx_empty ? 8'h00 : tx_mem[tx_rd[DEPTH_LOG2-1:0]];
  assign rx_head = rx_empty ? 8'h00 : rx_mem[rx_rd[DEPTH_LOG2-1:0]];

`ifdef SERIAL_ENDPOINT_LOOPBACK_EN
  assign lb_mode = bus.loopback_in;
`else
  assign lb_mode = 1'b0;
`endif
  assign lb_move = lb_mode && !tx_empty && !rx_full;

  assign bus.cpu_data_out      = rx_head;
  assign bus.cpu_valid_out     = !rx_empty;
  assign bus.cpu_ready_out     = !tx_full;
  assign bus.host_tx_data_out  = tx_head;
  assign bus.host_tx_valid_out = !tx_empty && !lb_mode;
  assign bus.host_rx_ready_out = !rx_full && !lb_mode;
  assign bus.overflow_out      = overflow;
  assign bus.underflow_out     = underflow;

  // Loopback and host link never both move bytes: the host handshakes are gated off.
  assign tx_push      = bus.cpu_wren_in && !tx_full;
  assign tx_pop       = lb_move || (!lb_mode && !tx_empty && bus.host_tx_ready_in);
  assign rx_push      = lb_move || (!lb_mode && !rx_full && bus.host_rx_valid_in);
  assign rx_push_data = lb_move ? tx_head : bus.host_rx_data_in;
  assign rx_pop       = bus.cpu_rden_in && !rx_empty;

  // NOTE: storage arrays carry no reset; the pointers alone define what is valid,
  // which keeps the arrays mappable to plain RAM.
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr[DEPTH_LOG2-1:0]] <= bus.cpu_data_in;
    if (rx_push) rx_mem[rx_wr[DEPTH_LOG2-1:0]] <= rx_push_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every update in
  // this block sees the same pre-edge values of the flags computed above.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_wr     <= '0;
      tx_rd     <= '0;
      rx_wr     <= '0;
      rx_rd     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + ptr_t'(1);
      if (tx_pop)  tx_rd <= tx_rd + ptr_t'(1);
      if (rx_push) rx_wr <= rx_wr + ptr_t'(1);
      if (rx_pop)  rx_rd <= rx_rd + ptr_t'(1);
      // A set event outranks a coincident clear.
      if (bus.cpu_wren_in && tx_full)       overflow <= 1'b1;
      else if (bus.clear_err_in)            overflow <= 1'b0;
      if (bus.cpu_rden_in && rx_empty)      underflow <= 1'b1;
      else if (bus.clear_err_in)            underflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_serial_endpoint.sv
// Self-checking bench for serial_endpoint: directed scenarios then random traffic,
// compared every cycle against a queue-based reference model.
module tb_serial_endpoint;
  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;

  serial_endpoint_if bus ();

  serial_endpoint #(.DEPTH_LOG2(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  bit ovf_m = 1'b0;
  bit unf_m = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("cpu_valid",  {7'b0, bus.cpu_valid_out},     {7'b0, rx_q.size() != 0});
    chk("cpu_ready",  {7'b0, bus.cpu_ready_out},     {7'b0, tx_q.size() != DEPTH});
    chk("cpu_data",   bus.cpu_data_out,              (rx_q.size() != 0) ? rx_q[0] : 8'h00);
    chk("host_tx_valid", {7'b0, bus.host_tx_valid_out},
        {7'b0, (tx_q.size() != 0) && !lb_now()});
    chk("host_tx_data", bus.host_tx_data_out,        (tx_q.size() != 0) ? tx_q[0] : 8'h00);
    chk("host_rx_ready", {7'b0, bus.host_rx_ready_out},
        {7'b0, (rx_q.size() != DEPTH) && !lb_now()});
    chk("overflow",   {7'b0, bus.overflow_out},      {7'b0, ovf_m});
    chk("underflow",  {7'b0, bus.underflow_out},     {7'b0, unf_m});
  endtask

  function automatic bit lb_now();
`ifdef SERIAL_ENDPOINT_LOOPBACK_EN
    return bus.loopback_in;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: what the next clock edge does to the byte queues and sticky flags.
  task automatic model_step();
    bit lb, tx_e, tx_f, rx_e, rx_f, move;
    logic [7:0] moved;
    if (reset) begin
      tx_q.delete();
      rx_q.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
      return;
    end
    lb    = lb_now();
    tx_e  = (tx_q.size() == 0);
    tx_f  = (tx_q.size() == DEPTH);
    rx_e  = (rx_q.size() == 0);
    rx_f  = (rx_q.size() == DEPTH);
    move  = lb && !tx_e && !rx_f;
    moved = tx_e ? 8'h00 : tx_q[0];
    if (bus.cpu_rden_in && !rx_e) void'(rx_q.pop_front());
    if (move) rx_q.push_back(moved);
    else if (!lb && bus.host_rx_valid_in && !rx_f) rx_q.push_back(bus.host_rx_data_in);
    if (move || (!lb && !tx_e && bus.host_tx_ready_in)) void'(tx_q.pop_front());
    if (bus.cpu_wren_in && !tx_f) tx_q.push_back(bus.cpu_data_in);
    if (bus.cpu_wren_in && tx_f) ovf_m = 1'b1;
    else if (bus.clear_err_in)   ovf_m = 1'b0;
    if (bus.cpu_rden_in && rx_e) unf_m = 1'b1;
    else if (bus.clear_err_in)   unf_m = 1'b0;
  endtask

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic tick();
    model_step();
    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask

  task automatic idle();
    bus.cpu_wren_in      = 1'b0;
    bus.cpu_data_in      = 8'h00;
    bus.cpu_rden_in      = 1'b0;
    bus.host_tx_ready_in = 1'b0;
    bus.host_rx_data_in  = 8'h00;
    bus.host_rx_valid_in = 1'b0;
    bus.clear_err_in     = 1'b0;
`ifdef SERIAL_ENDPOINT_LOOPBACK_EN
    bus.loopback_in      = 1'b0;
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_cpu_valid", {7'b0, bus.cpu_valid_out}, 8'h00);
    chk("rst_host_tx_valid", {7'b0, bus.host_tx_valid_out}, 8'h00);
    chk("rst_cpu_ready", {7'b0, bus.cpu_ready_out}, 8'h01);
    chk("rst_host_rx_ready", {7'b0, bus.host_rx_ready_out}, 8'h01);
    chk("rst_flags", {6'b0, bus.overflow_out, bus.underflow_out}, 8'h00);
    chk("rst_data", bus.cpu_data_out | bus.host_tx_data_out, 8'h00);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    idle();
    @(negedge clock);
    do_reset();

    // Reset discards buffered bytes mid-stream.
    for (int i = 0; i < 3; i++) begin
      bus.cpu_wren_in = 1'b1;
      bus.cpu_data_in = 8'hC0 + 8'(i);
      tick();
    end
    idle();
    chk("pre_rst_tx_valid", {7'b0, bus.host_tx_valid_out}, 8'h01);
    do_reset();
    tick();

    // CPU write path with host stalled, then released.
    for (int i = 0; i < 3; i++) begin
      bus.cpu_wren_in = 1'b1;
      bus.cpu_data_in = 8'h41 + 8'(i);
      tick();
    end
    idle();
    bus.host_tx_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("tx_stream", bus.host_tx_data_out, 8'h41 + 8'(i));
      tick();
    end
    chk("tx_drained", {7'b0, bus.host_tx_valid_out}, 8'h00);
    idle();

    // TX overflow: ninth byte dropped.
    for (int i = 0; i < 9; i++) begin
      bus.cpu_wren_in = 1'b1;
      bus.cpu_data_in = 8'(i);
      tick();
      if (i == 7) chk("tx_full_ready", {7'b0, bus.cpu_ready_out}, 8'h00);
    end
    idle();
    chk("ovf_set", {7'b0, bus.overflow_out}, 8'h01);
    bus.host_tx_ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_stream", bus.host_tx_data_out, 8'(i));
      tick();
    end
    chk("ovf_drained", {7'b0, bus.host_tx_valid_out}, 8'h00);
    idle();
    bus.clear_err_in = 1'b1;
    tick();
    idle();
    chk("ovf_clear", {7'b0, bus.overflow_out}, 8'h00);

    // Host to CPU, then underflow.
    bus.host_rx_valid_in = 1'b1;
    bus.host_rx_data_in  = 8'h5A;
    tick();
    bus.host_rx_data_in  = 8'hA5;
    tick();
    idle();
    chk("rx_first", bus.cpu_data_out, 8'h5A);
    bus.cpu_rden_in = 1'b1;
    tick();
    chk("rx_second", bus.cpu_data_out, 8'hA5);
    tick();
    tick();
    idle();
    chk("unf_set", {7'b0, bus.underflow_out}, 8'h01);
    chk("unf_data", bus.cpu_data_out, 8'h00);
    bus.clear_err_in = 1'b1;
    tick();
    idle();

    // Simultaneous RX push/pop at occupancy 4, then on a full FIFO.
    bus.host_rx_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.host_rx_data_in = 8'h80 + 8'(i);
      tick();
    end
    bus.cpu_rden_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.host_rx_data_in = 8'h90 + 8'(i);
      tick();
    end
    chk("rx_occ4", 8'(rx_q.size()), 8'd4);
    bus.cpu_rden_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.host_rx_data_in = 8'hB0 + 8'(i);
      tick();
    end
    chk("rx_full_ready", {7'b0, bus.host_rx_ready_out}, 8'h00);
    bus.cpu_rden_in     = 1'b1;
    bus.host_rx_data_in = 8'hEE;
    tick();
    idle();
    chk("rx_full_refused", {7'b0, bus.host_rx_ready_out}, 8'h01);
    bus.cpu_rden_in = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    idle();
    bus.clear_err_in = 1'b1;
    tick();
    idle();

`ifdef SERIAL_ENDPOINT_LOOPBACK_EN
    // Loopback: CPU writes echo back to CPU reads.
    bus.loopback_in = 1'b1;
    bus.cpu_wren_in = 1'b1;
    bus.cpu_data_in = 8'h10;
    tick();
    chk("lb_valid_1", {7'b0, bus.cpu_valid_out}, 8'h00);
    bus.cpu_data_in = 8'h20;
    tick();
    chk("lb_valid_2", {7'b0, bus.cpu_valid_out}, 8'h01);
    bus.cpu_wren_in = 1'b0;
    tick();
    chk("lb_data_1", bus.cpu_data_out, 8'h10);
    bus.cpu_rden_in = 1'b1;
    tick();
    chk("lb_data_2", bus.cpu_data_out, 8'h20);
    tick();
    idle();
    bus.loopback_in = 1'b1;
    chk("lb_empty", {7'b0, bus.cpu_valid_out}, 8'h00);
    tick();
    idle();
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bus.cpu_wren_in      = ($urandom_range(0, 99) < 45);
      bus.cpu_data_in      = 8'($urandom);
      bus.cpu_rden_in      = ($urandom_range(0, 99) < 40);
      bus.host_tx_ready_in = ($urandom_range(0, 99) < 35);
      bus.host_rx_valid_in = ($urandom_range(0, 99) < 50);
      bus.host_rx_data_in  = 8'($urandom);
      bus.clear_err_in     = ($urandom_range(0, 99) < 8);
`ifdef SERIAL_ENDPOINT_LOOPBACK_EN
      if ($urandom_range(0, 99) < 10) bus.loopback_in = ~bus.loopback_in;
`endif
      tick();
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
